// File: rtl/bus_xfer.sv
// Command-driven bus transfer engine: a FIFO of {src,dst} commands feeds
// a 3-state sequencer that drives one source onto the bus, then strobes one
// destination.
//
// Ports:
//   i_clk, i_reset      clock, async active-high reset
//   i_cmdValid/o_cmdReady  command handshake; i_cmdSrc/i_cmdDst carry indices
//   i_srcData           packed source data, source k at [k*WIDTH +: WIDTH]
//   o_srcOe, o_dstWr    one-hot source enable / destination write strobe
//   o_bus               value of the enabled source (0 when idle)
//   o_busy              sequencer active or commands pending
//   o_err, i_errClr     sticky illegal-index flag and its clear
//   o_xferCount         completed-transfer counter (wraps)
module bus_xfer #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 4,
  parameter int NDST  = 4,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cmdValid,
  output logic                     o_cmdReady,
  input  logic [$clog2(NSRC)-1:0]  i_cmdSrc,
  input  logic [$clog2(NDST)-1:0]  i_cmdDst,
  input  logic [NSRC*WIDTH-1:0]    i_srcData,
  output logic [NSRC-1:0]          o_srcOe,
  output logic [NDST-1:0]          o_dstWr,
  output logic [WIDTH-1:0]         o_bus,
  output logic                     o_busy,
  output logic                     o_err,
  input  logic                     i_errClr,
  output logic [15:0]              o_xferCount
);

  localparam int SW = $clog2(NSRC);
  localparam int DW = $clog2(NDST);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = SW + DW;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WRITE
  } state_e;

  state_e            state_q;
  logic [NSRC-1:0]   oe_q;
  logic [NDST-1:0]   wr_q;
  logic [DW-1:0]     dst_q;
  logic              err_q;
  logic [15:0]       xfer_q;

  logic [CW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [AW:0]       cnt_q;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [CW-1:0]     head;
  logic [SW-1:0]     head_src;
  logic [DW-1:0]     head_dst;
  logic [NSRC-1:0]   head_src_oh;
  logic [NDST-1:0]   head_dst_oh;
  logic [NDST-1:0]   dst_q_oh;
  logic              head_bad;
  logic [WIDTH-1:0]  bus;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  // Ready depends only on the stored count, so a full FIFO refuses a push
  // even when a pop happens on the same edge.
  assign push     = i_cmdValid & ~full;
  assign pop      = ~empty & (state_q != DRIVE);
  assign head     = mem_q[rptr_q];
  assign head_src = head[CW-1:DW];
  assign head_dst = head[DW-1:0];

  // One-hot decode; an index beyond the populated range decodes to zero,
  // which doubles as the illegal-index detector.
  always_comb begin
    head_src_oh = '0;
    head_dst_oh = '0;
    dst_q_oh    = '0;
    for (int k = 0; k < NSRC; k++) begin
      head_src_oh[k] = (head_src == SW'(k));
    end
    for (int k = 0; k < NDST; k++) begin
      head_dst_oh[k] = (head_dst == DW'(k));
      dst_q_oh[k]    = (dst_q == DW'(k));
    end
  end

  assign head_bad = ~(|head_src_oh) | ~(|head_dst_oh);

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wptr_q] <= {i_cmdSrc, i_cmdDst};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!push && pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      oe_q    <= '0;
      wr_q    <= '0;
      dst_q   <= '0;
      err_q   <= 1'b0;
      xfer_q  <= '0;
    end else begin
      wr_q <= '0;
      if (i_errClr) begin
        err_q <= 1'b0;
      end
      unique case (state_q)
        IDLE, WRITE: begin
          if (state_q == WRITE) begin
            xfer_q <= xfer_q + 16'd1;
          end
          if (pop && !head_bad) begin
            state_q <= DRIVE;
            oe_q    <= head_src_oh;
            dst_q   <= head_dst;
          end else begin
            state_q <= IDLE;
            oe_q    <= '0;
            // A set on the same edge overrides the clear above.
            if (pop) begin
              err_q <= 1'b1;
            end
          end
        end
        DRIVE: begin
          state_q <= WRITE;
          wr_q    <= dst_q_oh;
        end
        default: begin
          state_q <= IDLE;
          oe_q    <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (oe_q[k]) begin
        bus = bus | i_srcData[k*WIDTH +: WIDTH];
      end
    end
  end

  assign o_cmdReady  = ~full;
  assign o_srcOe     = oe_q;
  assign o_dstWr     = wr_q;
  assign o_bus       = bus;
  assign o_busy      = (state_q != IDLE) | ~empty;
  assign o_err       = err_q;
  assign o_xferCount = xfer_q;

endmodule

// File: tb/tb_bus_xfer.sv
// Directed self-checking bench for bus_xfer (NSRC=3 so source index 3 is
// illegal; WIDTH=8, NDST=4, DEPTH=4).
module tb_bus_xfer;

  logic        clk;
  logic        i_reset;
  logic        i_cmdValid;
  logic        o_cmdReady;
  logic [1:0]  i_cmdSrc;
  logic [1:0]  i_cmdDst;
  logic [23:0] i_srcData;
  logic [2:0]  o_srcOe;
  logic [3:0]  o_dstWr;
  logic [7:0]  o_bus;
  logic        o_busy;
  logic        o_err;
  logic        i_errClr;
  logic [15:0] o_xferCount;

  int n_checks;
  int n_fail;

  bus_xfer #(
    .WIDTH(8),
    .NSRC (3),
    .NDST (4),
    .DEPTH(4)
  ) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_cmdValid (i_cmdValid),
    .o_cmdReady (o_cmdReady),
    .i_cmdSrc   (i_cmdSrc),
    .i_cmdDst   (i_cmdDst),
    .i_srcData  (i_srcData),
    .o_srcOe    (o_srcOe),
    .o_dstWr    (o_dstWr),
    .o_bus      (o_bus),
    .o_busy     (o_busy),
    .o_err      (o_err),
    .i_errClr   (i_errClr),
    .o_xferCount(o_xferCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sdat(int s);
    case (s)
      0: sdat = 8'h5A;
      1: sdat = 8'h3C;
      default: sdat = 8'hA5;
    endcase
  endfunction

  task automatic apply_reset();
    i_cmdValid = 1'b0;
    i_errClr   = 1'b0;
    i_reset    = 1'b1;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset    = 1'b1;
    i_cmdValid = 1'b1;
    i_cmdSrc   = 2'd0;
    i_cmdDst   = 2'd3;
    #1;
    n_checks++;
    if ({o_srcOe, o_dstWr, o_bus, o_busy, o_err, o_xferCount} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: oe=%b wr=%b bus=%h busy=%b err=%b cnt=%h want all 0",
               o_srcOe, o_dstWr, o_bus, o_busy, o_err, o_xferCount);
    end
    n_checks++;
    if (o_cmdReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", o_cmdReady);
    end
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    // valid stays high: first edge after deassertion must accept it
    @(posedge clk);
    #1;
    i_cmdValid = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_push: busy=%b want 1", o_busy);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    apply_reset();
    i_cmdValid = 1'b1;
    i_cmdSrc   = 2'd2;
    i_cmdDst   = 2'd1;
    @(posedge clk);
    #1;
    i_cmdValid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) begin
        n_checks++;
        if (o_srcOe !== 3'b100 || o_bus !== 8'hA5) begin
          n_fail++;
          $display("FAIL single_drive%0d: oe=%b bus=%h want 100 a5", i, o_srcOe, o_bus);
        end
      end
      n_checks++;
      if (o_dstWr !== ((i == 2) ? 4'b0010 : 4'b0000)) begin
        n_fail++;
        $display("FAIL single_wr%0d: got %b", i, o_dstWr);
      end
    end
    n_checks++;
    if (o_xferCount !== 16'd1 || o_busy !== 1'b0 || o_srcOe !== 3'b000 || o_bus !== 8'h00) begin
      n_fail++;
      $display("FAIL single_done: cnt=%h busy=%b oe=%b bus=%h want 1 0 0 0",
               o_xferCount, o_busy, o_srcOe, o_bus);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] srcs [4];
    logic [3:0] exp_wr [12];
    logic [1:0] src_at_wr [12];
    srcs      = '{2'd0, 2'd1, 2'd2, 2'd0};
    exp_wr    = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0};
    src_at_wr = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin
        i_cmdValid = 1'b1;
        i_cmdSrc   = srcs[i];
        i_cmdDst   = 2'(i);
        n_checks++;
        if (o_cmdReady !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready%0d: got %b want 1", i, o_cmdReady);
        end
      end else begin
        i_cmdValid = 1'b0;
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (o_dstWr !== exp_wr[i]) begin
        n_fail++;
        $display("FAIL b2b_wr%0d: got %b want %b", i, o_dstWr, exp_wr[i]);
      end
      if (exp_wr[i] != 4'h0) begin
        n_checks++;
        if (o_bus !== sdat(int'(src_at_wr[i]))) begin
          n_fail++;
          $display("FAIL b2b_bus%0d: got %h want %h", i, o_bus, sdat(int'(src_at_wr[i])));
        end
      end
    end
    n_checks++;
    if (o_xferCount !== 16'd4 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: cnt=%0d busy=%b want 4 0", o_xferCount, o_busy);
    end
  endtask

  task automatic test_full();
    int k;
    int p;
    logic rdy;
    k = 0;
    p = 0;
    apply_reset();
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (k < 10) begin
        i_cmdValid = 1'b1;
        i_cmdSrc   = 2'(k % 3);
        i_cmdDst   = 2'(k % 4);
      end else begin
        i_cmdValid = 1'b0;
      end
      rdy = o_cmdReady;
      if (cyc == 6 || cyc == 7) begin
        n_checks++;
        if (rdy !== (cyc == 6)) begin
          n_fail++;
          $display("FAIL full_ready%0d: got %b want %b", cyc, rdy, cyc == 6);
        end
      end
      @(posedge clk);
      #1;
      if (i_cmdValid && rdy) k++;
      if (o_dstWr != 4'h0) begin
        n_checks++;
        if (p >= 10 || o_dstWr !== 4'(1 << (p % 4)) || o_bus !== sdat(p % 3)) begin
          n_fail++;
          $display("FAIL full_order%0d: wr=%b bus=%h want %b %h",
                   p, o_dstWr, o_bus, 4'(1 << (p % 4)), sdat(p % 3));
        end
        p++;
      end
    end
    n_checks++;
    if (k !== 10 || p !== 10 || o_xferCount !== 16'd10 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_end: acc=%0d pulses=%0d cnt=%0d busy=%b want 10 10 10 0",
               k, p, o_xferCount, o_busy);
    end
  endtask

  task automatic test_illegal();
    int pulses;
    pulses = 0;
    apply_reset();
    i_cmdValid = 1'b1;
    i_cmdSrc   = 2'd3;
    i_cmdDst   = 2'd0;
    @(posedge clk);
    #1;
    i_cmdSrc = 2'd0;
    @(posedge clk);
    #1;
    i_cmdValid = 1'b0;
    n_checks++;
    if (o_err !== 1'b1 || o_srcOe !== 3'b000 || o_dstWr !== 4'h0) begin
      n_fail++;
      $display("FAIL illegal_pop: err=%b oe=%b wr=%b want 1 000 0000", o_err, o_srcOe, o_dstWr);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (o_srcOe !== 3'b001 || o_bus !== 8'h5A) begin
      n_fail++;
      $display("FAIL illegal_next: oe=%b bus=%h want 001 5a", o_srcOe, o_bus);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (o_dstWr != 4'h0) pulses++;
    end
    n_checks++;
    if (pulses !== 1 || o_xferCount !== 16'd1 || o_err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_end: pulses=%0d cnt=%0d err=%b want 1 1 1",
               pulses, o_xferCount, o_err);
    end
  endtask

  task automatic test_err_clear();
    apply_reset();
    i_cmdValid = 1'b1;
    i_cmdSrc   = 2'd3;
    i_cmdDst   = 2'd1;
    @(posedge clk);
    #1;
    i_cmdValid = 1'b0;
    i_errClr   = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (o_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_race: got %b want 1", o_err);
    end
    @(posedge clk);
    #1;
    i_errClr = 1'b0;
    n_checks++;
    if (o_err !== 1'b0 || o_xferCount !== 16'd0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b cnt=%0d want 0 0", o_err, o_xferCount);
    end
  endtask

  task automatic test_reset_midop();
    int pulses;
    pulses = 0;
    apply_reset();
    i_cmdValid = 1'b1;
    i_cmdSrc   = 2'd1;
    i_cmdDst   = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    i_cmdValid = 1'b0;
    n_checks++;
    if (o_dstWr !== 4'b0100) begin
      n_fail++;
      $display("FAIL midop_write: got %b want 0100", o_dstWr);
    end
    #2;
    i_reset = 1'b1;
    #1;
    n_checks++;
    if ({o_dstWr, o_srcOe, o_bus, o_busy, o_xferCount} !== '0 || o_cmdReady !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_reset: wr=%b oe=%b bus=%h busy=%b cnt=%h rdy=%b",
               o_dstWr, o_srcOe, o_bus, o_busy, o_xferCount, o_cmdReady);
    end
    @(negedge clk);
    i_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (o_dstWr != 4'h0) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || o_xferCount !== 16'd0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_after: pulses=%0d cnt=%0d busy=%b want 0 0 0",
               pulses, o_xferCount, o_busy);
    end
    force dut.xfer_q = 16'hFFFF;
    #1;
    release dut.xfer_q;
    n_checks++;
    if (o_xferCount !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_preset: got %h want ffff", o_xferCount);
    end
    i_cmdValid = 1'b1;
    i_cmdSrc   = 2'd0;
    i_cmdDst   = 2'd0;
    @(posedge clk);
    #1;
    i_cmdValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (o_xferCount !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap: got %h want 0000", o_xferCount);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    i_reset    = 1'b1;
    i_cmdValid = 1'b0;
    i_cmdSrc   = '0;
    i_cmdDst   = '0;
    i_errClr   = 1'b0;
    i_srcData  = {8'hA5, 8'h3C, 8'h5A};
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_illegal();
    test_err_clear();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_xfer.md
BUS_XFER -- requirements
Module: bus_xfer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bus width in bits.
REQ-002 The block SHALL have parameter NSRC, default 4, meaning number of bus sources (2..16).
REQ-003 The block SHALL have parameter NDST, default 4, meaning number of bus destinations (2..16).
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning command FIFO depth (power of 2, at least 2).
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port i_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port i_cmdValid, input, 1 bit: command offered.
REQ-008 The block SHALL have port o_cmdReady, output, 1 bit: FIFO can accept a command.
REQ-009 The block SHALL have port i_cmdSrc, input, clog2(NSRC) bits: source index.
REQ-010 The block SHALL have port i_cmdDst, input, clog2(NDST) bits: destination index.
REQ-011 The block SHALL have port i_srcData, input, NSRC*WIDTH bits: source k occupies bits [k*WIDTH +: WIDTH].
REQ-012 The block SHALL have port o_srcOe, output, NSRC bits: one-hot source output enable.
REQ-013 The block SHALL have port o_dstWr, output, NDST bits: one-hot destination write strobe.
REQ-014 The block SHALL have port o_bus, output, WIDTH bits: muxed bus value.
REQ-015 The block SHALL have port o_busy, output, 1 bit: the FSM is not IDLE or the FIFO is non-empty.
REQ-016 The block SHALL have port o_err, output, 1 bit: sticky illegal-index flag.
REQ-017 The block SHALL have port i_errClr, input, 1 bit: clears o_err.
REQ-018 The block SHALL have port o_xferCount, output, 16 bits: completed-transfer counter.

Function
REQ-019 o_cmdReady SHALL equal the FIFO-not-full condition; a command SHALL be pushed on a rising edge where i_cmdValid and o_cmdReady are both high.
REQ-020 When the FIFO is full, a push SHALL be refused even if a pop occurs in the same cycle.
REQ-021 The FSM SHALL have exactly three states: IDLE, DRIVE and WRITE.
REQ-022 In IDLE with the FIFO non-empty, the block SHALL pop the head command at the next edge and enter DRIVE.
REQ-023 DRIVE SHALL always go to WRITE after one cycle.
REQ-024 On leaving WRITE, the FSM SHALL pop the next command and enter DRIVE if the FIFO is non-empty, and SHALL otherwise enter IDLE; sustained throughput SHALL therefore be one transfer per 2 cycles.
REQ-025 During DRIVE and WRITE, o_srcOe[src] SHALL be high and o_bus SHALL equal the selected i_srcData slice.
REQ-026 In IDLE, o_srcOe SHALL be 0 and o_bus SHALL be 0.
REQ-027 o_dstWr[dst] SHALL be high during WRITE only, for exactly one cycle per transfer.
REQ-028 o_xferCount SHALL increment on the edge that leaves WRITE, and SHALL wrap from 0xFFFF to 0x0000.
REQ-029 Latency SHALL be as follows: a push at edge t gives DRIVE after edge t+1, WRITE after t+2, and the count update at edge t+3.
REQ-030 A popped command with src >= NSRC or dst >= NDST SHALL be discarded: no OE, no strobe, no count; o_err SHALL be set at that edge; and the FSM SHALL stay in IDLE (or go to IDLE from WRITE).
REQ-031 o_err SHALL clear on an edge with i_errClr high unless a new illegal command is popped on the same edge; setting SHALL take priority over clearing.
REQ-032 The FIFO SHALL preserve command order.
REQ-033 Outputs o_srcOe, o_dstWr, o_bus and o_busy SHALL be decoded from registered state only, with no combinational path from i_cmdValid.

Reset
REQ-034 Asserting i_reset SHALL immediately force IDLE, an empty FIFO, o_err=0, o_xferCount=0, o_srcOe=0, o_dstWr=0, o_bus=0 and o_busy=0.
REQ-035 Immediately on reset, o_cmdReady SHALL be 1.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer with no strobe and no count.
REQ-037 Deassertion of reset SHALL be safe on any cycle; the first push SHALL be possible on the first edge after deassertion.

Verification
REQ-038 Single transfer: WIDTH=8, i_srcData slice 2=0xA5, push {src=2,dst=1} at edge t -> o_srcOe=0100 and o_bus=0xA5 after t+1 and t+2, o_dstWr=0010 only after t+2, o_xferCount=1 after t+3.
REQ-039 Back-to-back: push 4 commands on consecutive cycles -> o_cmdReady stays 1, four WRITE pulses exactly 2 cycles apart in push order, o_xferCount=4, o_busy low after the last WRITE.
REQ-040 Full FIFO: hold i_cmdValid with DEPTH=4 while the FSM is stalled in DRIVE/WRITE -> o_cmdReady=0 once 4 entries are queued, no command lost or duplicated, order preserved.
REQ-041 Illegal index: NSRC=3, push {src=3,dst=0} then {src=0,dst=0} -> first command yields no OE or strobe and o_err=1; second completes normally; o_xferCount=1.
REQ-042 Error clear race: i_errClr high on the same edge an illegal command pops -> o_err stays 1; i_errClr on the next edge -> o_err=0.
REQ-043 Reset mid-op: assert i_reset during WRITE with 2 commands queued -> o_dstWr drops at once, FIFO empty, o_xferCount=0, o_cmdReady=1; o_xferCount preset to 0xFFFF then one transfer -> 0x0000.
